// File: rtl/fruit_spawner.sv
// fruit_spawner: places the fruit on the 80x60 cell grid of the 800x600 playfield and
// respawns it after every eat. Candidate cells come from a free-running 16-bit LFSR,
// filtered by rejection sampling; after MAX_TRIES rejections a fixed fallback cell is used.
// Also keeps a saturating count of fruits eaten.
//
// Ports:
//   uclk            system clock, rising edge
//   reset           synchronous, active-low
//   comer           level-held eat flag from game logic (rising edge = eat event)
//   fruitPositionX  fruit cell centre X in pixels (registered)
//   fruitPositionY  fruit cell centre Y in pixels (registered)
//   Rfruta/Gfruta/Bfruta  fruit colour (registered)
//   score           fruits eaten, saturating at 255
//   busy            high while a respawn is in progress
module fruit_spawner #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic        uclk,
  input  logic        reset,
  input  logic        comer,
  output logic [11:0] fruitPositionX,
  output logic [11:0] fruitPositionY,
  output logic [2:0]  Rfruta,
  output logic [2:0]  Gfruta,
  output logic [1:0]  Bfruta,
  output logic [7:0]  score,
  output logic        busy
);

  typedef enum logic [1:0] {StShow, StPick, StCommit} state_e;

  localparam logic [7:0] MaxTries = 8'(MAX_TRIES);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        comer_q;
  logic [7:0]  tries_q, tries_d;
  logic [6:0]  cand_col_q, cand_col_d;
  logic [5:0]  cand_row_q, cand_row_d;
  logic [6:0]  cur_col_q, cur_col_d;
  logic [5:0]  cur_row_q, cur_row_d;
  logic [1:0]  pal_q, pal_d;
  logic [7:0]  score_q, score_d;
  logic [11:0] pos_x_q, pos_x_d;
  logic [11:0] pos_y_q, pos_y_d;
  logic [7:0]  rgb_q, rgb_d;

  logic       eat;
  logic [6:0] samp_col;
  logic [5:0] samp_row;
  logic       samp_ok;
  logic       on_centre;
  logic [7:0] tries_inc;

  // Cell index to pixel centre: c*10 + 5 using shifts only.
  function automatic logic [11:0] cell_to_px(input logic [6:0] c);
    logic [11:0] c12;
    c12 = {5'd0, c};
    return (c12 << 3) + (c12 << 1) + 12'd5;
  endfunction

  // {R[2:0], G[2:0], B[1:0]}; no blue (snake) and no white (background).
  function automatic logic [7:0] pal_rgb(input logic [1:0] idx);
    logic [7:0] rgb;
    unique case (idx)
      2'd0:    rgb = 8'b111_000_00;  // red
      2'd1:    rgb = 8'b111_111_00;  // yellow
      2'd2:    rgb = 8'b111_000_11;  // magenta
      default: rgb = 8'b111_100_00;  // orange
    endcase
    return rgb;
  endfunction

  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    eat       = comer & ~comer_q;
    samp_col  = lfsr_q[6:0];
    samp_row  = lfsr_q[13:8];
    samp_ok   = (samp_col < 7'd80) && (samp_row < 6'd60) &&
                !((samp_col == cur_col_q) && (samp_row == cur_row_q));
    on_centre = (cur_col_q == 7'd40) && (cur_row_q == 6'd30);
    tries_inc = tries_q + 8'd1;

    state_d    = state_q;
    tries_d    = tries_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    pal_d      = pal_q;
    score_d    = score_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    rgb_d      = rgb_q;

    unique case (state_q)
      StShow: begin
        if (eat) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          tries_d = 8'd0;
          state_d = StPick;
        end
      end
      StPick: begin
        if (samp_ok) begin
          cand_col_d = samp_col;
          cand_row_d = samp_row;
          state_d    = StCommit;
        end else begin
          tries_d = tries_inc;
          if (tries_inc >= MaxTries) begin
            // Fallback must also differ from the displayed cell.
            cand_col_d = on_centre ? 7'd10 : 7'd40;
            cand_row_d = on_centre ? 6'd10 : 6'd30;
            state_d    = StCommit;
          end
        end
      end
      StCommit: begin
        pos_x_d   = cell_to_px(cand_col_q);
        pos_y_d   = cell_to_px({1'b0, cand_row_q});
        cur_col_d = cand_col_q;
        cur_row_d = cand_row_q;
        pal_d     = pal_q + 2'd1;
        rgb_d     = pal_rgb(pal_q + 2'd1);
        state_d   = StShow;
      end
      default: state_d = StShow;
    endcase
  end

  always_ff @(posedge uclk) begin
    if (!reset) begin
      state_q    <= StShow;
      lfsr_q     <= SEED;
      comer_q    <= 1'b0;
      tries_q    <= 8'd0;
      cand_col_q <= 7'd0;
      cand_row_q <= 6'd0;
      cur_col_q  <= 7'd20;
      cur_row_q  <= 6'd15;
      pal_q      <= 2'd0;
      score_q    <= 8'd0;
      pos_x_q    <= 12'd205;
      pos_y_q    <= 12'd155;
      rgb_q      <= 8'b111_000_00;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      comer_q    <= comer;
      tries_q    <= tries_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      pal_q      <= pal_d;
      score_q    <= score_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      rgb_q      <= rgb_d;
    end
  end

  assign fruitPositionX            = pos_x_q;
  assign fruitPositionY            = pos_y_q;
  assign {Rfruta, Gfruta, Bfruta}  = rgb_q;
  assign score                     = score_q;
  assign busy                      = (state_q != StShow);

endmodule

// File: tb/tb_fruit_spawner.sv
// Randomized bench for fruit_spawner. A main instance (default parameters) is checked
// against a reference model of the respawn rules; a second instance with MAX_TRIES=1
// exercises the fallback cells.
module tb_fruit_spawner;

  localparam logic [15:0] SeedM  = 16'hACE1;
  localparam int          TriesM = 16;
  localparam logic [15:0] SeedF  = 16'h5A3C;
  localparam int          TriesF = 1;

  logic        uclk;
  logic        reset, comer, reset_fb, comer_fb;
  logic [11:0] pos_x, pos_y, fb_x, fb_y;
  logic [2:0]  r_o, g_o, fb_r, fb_g;
  logic [1:0]  b_o, fb_b;
  logic [7:0]  score_o, fb_score;
  logic        busy_o, fb_busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state (main instance).
  logic [15:0] m_lfsr, m_lfsr_fb;
  int m_cc, m_cr, m_pal, m_score;

  fruit_spawner #(.SEED(SeedM), .MAX_TRIES(TriesM)) dut (
    .uclk(uclk), .reset(reset), .comer(comer),
    .fruitPositionX(pos_x), .fruitPositionY(pos_y),
    .Rfruta(r_o), .Gfruta(g_o), .Bfruta(b_o), .score(score_o), .busy(busy_o)
  );

  fruit_spawner #(.SEED(SeedF), .MAX_TRIES(TriesF)) dut_fb (
    .uclk(uclk), .reset(reset_fb), .comer(comer_fb),
    .fruitPositionX(fb_x), .fruitPositionY(fb_y),
    .Rfruta(fb_r), .Gfruta(fb_g), .Bfruta(fb_b), .score(fb_score), .busy(fb_busy)
  );

  initial uclk = 1'b0;
  always #5 uclk = ~uclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [7:0] pal_rgb(input int idx);
    case (idx % 4)
      0:       return 8'b111_000_00;
      1:       return 8'b111_111_00;
      2:       return 8'b111_000_11;
      default: return 8'b111_100_00;
    endcase
  endfunction

  // {X, Y, RGB} expected for a fruit at cell (c, r) with palette index p.
  function automatic logic [31:0] exp_pack(input int c, input int r, input int p);
    logic [11:0] x, y;
    x = 12'(c * 10 + 5);
    y = 12'(r * 10 + 5);
    return {x, y, pal_rgb(p)};
  endfunction

  function automatic logic [31:0] dut_pack();
    return {pos_x, pos_y, r_o, g_o, b_o};
  endfunction

  function automatic logic [31:0] fb_pack();
    return {fb_x, fb_y, fb_r, fb_g, fb_b};
  endfunction

  // Rejection sampling starting from first sample l0: returns chosen cell and the number of
  // cycles after the eat edge until the new fruit is visible.
  task automatic predict(input logic [15:0] l0, input int cc, input int cr, input int tries,
                         output int col, output int row, output int lat);
    logic [15:0] s;
    int c, r;
    bit done;
    s    = l0;
    done = 0;
    lat  = tries + 1;
    col  = (cc == 40 && cr == 30) ? 10 : 40;
    row  = (cc == 40 && cr == 30) ? 10 : 30;
    for (int i = 0; i < tries; i++) begin
      if (!done) begin
        c = int'(s[6:0]);
        r = int'(s[13:8]);
        if (c < 80 && r < 60 && !(c == cc && r == cr)) begin
          col  = c;
          row  = r;
          lat  = i + 2;
          done = 1;
        end
        s = lfsr_next(s);
      end
    end
  endtask

  // One clock edge; the model LFSRs follow the reset value seen at that edge.
  task automatic tick();
    logic rs, rf;
    rs = reset;
    rf = reset_fb;
    @(posedge uclk);
    m_lfsr    = rs ? lfsr_next(m_lfsr) : SeedM;
    m_lfsr_fb = rf ? lfsr_next(m_lfsr_fb) : SeedF;
    #1;
  endtask

  task automatic model_reset();
    m_cc = 20; m_cr = 15; m_pal = 0; m_score = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; reset_fb = 1'b0; comer = 1'b0; comer_fb = 1'b0;
    repeat (3) tick();
    reset = 1'b1; reset_fb = 1'b1;
    model_reset();
    check_val("rst_out",   dut_pack(), exp_pack(20, 15, 0));
    check_val("rst_score", {24'd0, score_o}, 32'd0);
    check_val("rst_busy",  {31'd0, busy_o}, 32'd0);
    check_val("rst_fb",    fb_pack(), exp_pack(20, 15, 0));
  endtask

  // One eat on the main instance. hold keeps comer high afterwards for extra cycles;
  // noise toggles comer randomly while the respawn runs.
  task automatic do_eat(input bit hold, input int extra, input bit noise);
    int col, row, lat;
    logic [31:0] old_p, new_p;
    comer = 1'b0;
    tick();
    comer = 1'b1;
    tick();  // E0
    if (m_score < 255) m_score++;
    predict(m_lfsr, m_cc, m_cr, TriesM, col, row, lat);
    old_p = exp_pack(m_cc, m_cr, m_pal);
    new_p = exp_pack(col, row, m_pal + 1);
    check_val("e0_score", {24'd0, score_o}, 32'(m_score));
    check_val("e0_busy",  {31'd0, busy_o}, 32'd1);
    for (int n = 1; n <= lat; n++) begin
      if (!hold && noise) comer = 1'($urandom_range(0, 1));
      tick();
      if (n < lat) begin
        check_val("hold_out", dut_pack(), old_p);
        check_val("busy_hi",  {31'd0, busy_o}, 32'd1);
      end else begin
        check_val("new_out",  dut_pack(), new_p);
        check_val("busy_lo",  {31'd0, busy_o}, 32'd0);
      end
      check_val("score", {24'd0, score_o}, 32'(m_score));
    end
    check_val("x_range", {31'd0, (pos_x >= 12'd5 && pos_x <= 12'd795)}, 32'd1);
    check_val("y_range", {31'd0, (pos_y >= 12'd5 && pos_y <= 12'd595)}, 32'd1);
    check_val("x_grid",  32'((pos_x - 12'd5) % 12'd10), 32'd0);
    check_val("y_grid",  32'((pos_y - 12'd5) % 12'd10), 32'd0);
    check_val("moved",   {31'd0, (dut_pack() != old_p)}, 32'd1);
    m_cc = col; m_cr = row; m_pal = (m_pal + 1) % 4;
    if (hold) begin
      for (int k = 0; k < extra; k++) begin
        tick();
        check_val("held_out",   dut_pack(), new_p);
        check_val("held_score", {24'd0, score_o}, 32'(m_score));
        check_val("held_busy",  {31'd0, busy_o}, 32'd0);
      end
    end
    comer = 1'b0;
  endtask

  // Wait (bounded) until the next fb eat edge will see a first sample with col >= 80.
  task automatic fb_fallback_eat(input int exp_c, input int exp_r, input int exp_pal,
                                 input int exp_score);
    logic [15:0] nx;
    bit found;
    comer_fb = 1'b0;
    tick();
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      nx = lfsr_next(m_lfsr_fb);
      if (nx[6:0] >= 7'd80) found = 1;
      else tick();
    end
    check_val("fb_search", {31'd0, found}, 32'd1);
    comer_fb = 1'b1;
    tick();
    check_val("fb_busy0", {31'd0, fb_busy}, 32'd1);
    tick();
    check_val("fb_hold",  {31'd0, fb_busy}, 32'd1);
    tick();
    check_val("fb_pos",   fb_pack(), exp_pack(exp_c, exp_r, exp_pal));
    check_val("fb_score", {24'd0, fb_score}, 32'(exp_score));
    check_val("fb_busy1", {31'd0, fb_busy}, 32'd0);
    comer_fb = 1'b0;
  endtask

  initial begin
    logic [31:0] rst_p;
    reset = 1'b0; reset_fb = 1'b0; comer = 1'b0; comer_fb = 1'b0;
    m_lfsr = SeedM; m_lfsr_fb = SeedF;
    model_reset();

    // Reset and a single clean eat.
    apply_reset();
    do_eat(0, 0, 0);
    check_val("first_yellow", {24'd0, r_o, g_o, b_o}, 32'(8'b111_111_00));
    check_val("first_score",  {24'd0, score_o}, 32'd1);

    // Held comer gives one respawn; drop and raise again gives a second.
    apply_reset();
    do_eat(1, 45, 0);
    check_val("held_one", {24'd0, score_o}, 32'd1);
    do_eat(0, 0, 0);
    check_val("second_score",   {24'd0, score_o}, 32'd2);
    check_val("second_magenta", {24'd0, r_o, g_o, b_o}, 32'(8'b111_000_11));

    // Fallback cells: (40,30), then (10,10) once the fruit sits on (40,30).
    fb_fallback_eat(40, 30, 1, 1);
    fb_fallback_eat(10, 10, 2, 2);

    // Reset during a respawn aborts it.
    apply_reset();
    do_eat(0, 0, 0);
    comer = 1'b0;
    tick();
    comer = 1'b1;
    tick();
    check_val("mid_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    comer = 1'b0;
    model_reset();
    rst_p = exp_pack(20, 15, 0);
    check_val("mid_rst_out",   dut_pack(), rst_p);
    check_val("mid_rst_score", {24'd0, score_o}, 32'd0);
    check_val("mid_rst_busy",  {31'd0, busy_o}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_val("no_commit", dut_pack(), rst_p);
      check_val("no_busy",   {31'd0, busy_o}, 32'd0);
    end

    // Many random eats: saturation, palette cycling, grid validity.
    apply_reset();
    for (int e = 0; e < 300; e++) begin
      comer = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      do_eat(0, 0, 1);
    end
    check_val("sat_score", {24'd0, score_o}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fruit_spawner.md
# fruit_spawner

Places the fruit that the snake chases and replaces it after each eat. It sits directly upstream of the game-logic/render stage: it drives `fruitPositionX`/`fruitPositionY` and `Rfruta`/`Gfruta`/`Bfruta` into that stage and consumes the `comer` pulse that stage raises when the snake head lands on the fruit. New positions come from a free-running LFSR, filtered by rejection sampling onto the 10-pixel cell grid of the 800x600 playfield. The block also keeps the eaten-fruit score.

## Interface
- `SEED`, 16'hACE1: LFSR load value on reset; must be nonzero.
- `MAX_TRIES`, 16: maximum sampling attempts per respawn before the fallback cell is used; range 1..255.
- `uclk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low (`reset`==0 resets on the next `uclk` edge).
- `comer` in 1: eat flag from game logic; level-held, may stay high many cycles.
- `fruitPositionX` out 12: fruit cell centre X in pixels, registered.
- `fruitPositionY` out 12: fruit cell centre Y in pixels, registered.
- `Rfruta` out 3, `Gfruta` out 3, `Bfruta` out 2: fruit colour, registered.
- `score` out 8: fruits eaten, saturating.
- `busy` out 1: high while a respawn is in progress (PICK or COMMIT).

## Operation
- **LFSR.** 16-bit Fibonacci LFSR that shifts every cycle regardless of state.
  - Shift rule: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - Reset loads `SEED`.
- **Eat edge detection.**
  - `comer_q` is a registered copy of `comer`; its reset value is 0.
  - An eat event is `comer & ~comer_q`.
- **FSM states: SHOW, PICK, COMMIT.**
- **SHOW** (reset state):
  - On an eat event: `score` increments (saturating at 255), the try counter clears, go to PICK.
  - Otherwise stay in SHOW.
- **PICK:**
  - Sample the current LFSR value: `col = lfsr[6:0]`, `row = lfsr[13:8]`.
  - Accept the sample if `col < 80`, `row < 60`, and (col,row) differs from the displayed cell.
  - Accepted: latch (col,row) and go to COMMIT.
  - Rejected: increment the try counter. If the counter reaches `MAX_TRIES`, latch the fallback cell and go to COMMIT; otherwise stay in PICK.
  - Fallback cell: col 40, row 30. If that is the displayed cell, use col 10, row 10 instead.
- **COMMIT:**
  - `fruitPositionX <= col*10 + 5` and `fruitPositionY <= row*10 + 5`.
  - Compute the multiply as `(c<<3)+(c<<1)` at 12-bit width; no truncation is possible, since the maximum values are 795 and 595.
  - The palette index advances mod 4; colour outputs take the new palette entry.
  - Go to SHOW.
- **Palette** (R,G,B):
  - 0 = red (111,000,00)
  - 1 = yellow (111,111,00)
  - 2 = magenta (111,000,11)
  - 3 = orange (111,100,00)
  - The palette never contains blue (snake colour) or white (background).
- **Reset values:**
  - `fruitPositionX`=205, `fruitPositionY`=155 (col 20, row 15).
  - Palette index 0, so colour outputs = red.
  - `score`=0, `busy`=0, state SHOW, try counter 0.
- **Boundary conditions:**
  - Eat events that arrive in PICK or COMMIT are ignored; they neither increment `score` nor cause a second respawn.
  - `comer` held high produces exactly one respawn. A new one requires `comer` to go low and then high again.
  - Reset asserted in PICK or COMMIT aborts the respawn and restores all reset values.
  - While `score`=255, eat events still trigger a respawn but `score` stays at 255.
  - Position and colour outputs stay stable, holding the previous fruit, throughout PICK. All of them change together on the same edge.

## Timing
- Let E0 be the edge where `comer`=1 and `comer_q`=0 are sampled in SHOW.
  - E0: `score` updates and state becomes PICK.
  - E1: first sample.
  - Accepted at E1: state COMMIT after E1; new position and colour appear after E2.
- Minimum latency is 2 cycles after E0. Worst case is `MAX_TRIES`+1 cycles after E0.
- `busy` is high from after E0 until after the COMMIT edge (the edge leaving COMMIT).
- All outputs are registered; there is no combinational path from `comer` to any output.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release → `fruitPositionX`=205, `fruitPositionY`=155, RGB=(111,000,00), `score`=0, `busy`=0.
- **Single eat:** one eat with `SEED`=16'hACE1; a bench LFSR model predicts the accepted (col,row) → outputs equal col*10+5 / row*10+5, on grid, differ from (205,155), colour becomes yellow, `score`=1, update exactly 2 cycles after E0 when the first sample is accepted.
- **Held comer:** hold `comer` high for 50 cycles → exactly one respawn and `score`=1. Drop `comer` for 1 cycle, raise it again → second respawn, `score`=2, colour magenta.
- **Fallback:** `MAX_TRIES`=1 with a `SEED` whose first PICK sample has col ≥ 80 → after COMMIT, position is (405,305).
- **Reset mid-respawn:** assert `reset`=0 during PICK → next cycle all reset values, state SHOW, no later COMMIT.
- **Saturation and grid validity:** 300 eat events → `score` stops at 255, palette cycles red→yellow→magenta→orange→red. Every committed position has X in 5..795, Y in 5..595, (X−5)%10==0, (Y−5)%10==0, and differs from the previous position.
